drop_turn_controller: RTL and testbench
=======================================

# drop_turn_controller

Sequences every move of a Connect Four game on `frame_clk`. It edge-detects column keys from `keycode`, alternates turns between red and black, and tracks the fill height of each column. It issues one placement request per accepted press to the board-cell registers and waits for the win checker's verdict before passing the turn. It sits between the keyboard path and the per-column board storage and is the only writer of board cells.

## Interface
- `NUM_COLS`, 7, board columns (A..G map to index 0..6)
- `NUM_ROWS`, 6, rows per column (row 0 = bottom)
- `frame_clk`  in  1  system clock, one cycle per frame
- `Reset`  in  1  synchronous, active-high; one clock, `frame_clk`
- `keycode`  in  8  current USB HID keycode, 0x00 = no key
- `place_ack`  in  1  board storage accepted the current placement
- `check_done`  in  1  win checker finished evaluating the last placement
- `win_found`  in  1  qualified by `check_done`: last placement completed four in a row
- `place_valid`  out  1  placement request pending
- `place_col`  out  3  column of the pending placement
- `place_row`  out  3  row of the pending placement
- `place_color`  out  1  0 = red, 1 = black
- `turn`  out  1  player to move (0 = red)
- `invalid`  out  1  one-cycle pulse: pressed column is full
- `game_over`  out  1  game ended
- `winner_valid`  out  1  `game_over` by win (0 = draw)
- `winner`  out  1  colour of the winner

## Operation
- Column keys: HID 0x1E..0x24 ('1'..'7') select columns 0..6. New-game key: 0x2C (space). All other codes are ignored.
- A press is accepted only when `keycode` differs from the previous cycle's registered value and is non-zero. A held key produces exactly one press.
- FSM states: WAIT_KEY, PLACE, CHECK, OVER.
- **WAIT_KEY:**
  - Column press with `height[c] == NUM_ROWS`: pulse `invalid`, stay in WAIT_KEY.
  - Column press otherwise: latch `place_col=c`, `place_row=height[c]`, `place_color=turn`, go to PLACE.
  - New-game key: ignored.
- **PLACE:** `place_valid=1`, outputs stable. On `place_ack`: `height[c]++`, `moves++`, go to CHECK. Key presses are ignored.
- **CHECK:** wait for `check_done`.
  - `win_found`: go to OVER, `winner_valid=1`, `winner=turn`.
  - Else if `moves == NUM_COLS*NUM_ROWS` (42): go to OVER, `winner_valid=0`.
  - Else: toggle `turn`, go to WAIT_KEY.
- **OVER:** `game_over=1`. Only the new-game key is honoured: it clears all heights, `moves`, `turn`, `winner*` and `game_over`, then goes to WAIT_KEY.
- Widths: `height[]` is 3 bits each (saturates at 6, never wraps). `moves` is 6 bits (0..42).

## Timing
- Reset values: state WAIT_KEY, all heights 0, `moves=0`, `turn=0`, all outputs 0. The previous-keycode register clears to 0x00.
- Reset in any state, including PLACE with the request unacknowledged, aborts in the same cycle. No placement is counted.
- Press recognised in cycle t: `place_valid` is high from t+1.
- `place_ack` is sampled only while `place_valid=1`. Ack in the first valid cycle gives a one-cycle request.
- `place_valid` falls in the cycle after ack. `height` updates the same edge.
- `check_done` is sampled only in CHECK. If it arrives in the first CHECK cycle, WAIT_KEY resumes the next cycle.
- `invalid` is high for exactly one cycle per rejected press.
- A key change during PLACE or CHECK is registered but never replayed later.

## Structure
- `connect4_pkg` holds:
  - the `NUM_COLS`/`NUM_ROWS` defaults
  - the `color_t` enum (RED=0, BLACK=1)
  - the FSM state enum
  - keycode constants `KEY_COL0..KEY_COL6` and `KEY_NEW_GAME`
- Sub-module `column_heights`: an array of seven 3-bit counters with `inc_en`/`inc_col`, `clr`, a read port `height[col]` and a `full[col]` vector.

## Test plan
- Reset, then key 0x1E held 10 cycles → one request: col 0, row 0, red. After ack and `check_done` with `win_found=0`: `turn=1`.
- Six alternating presses of 0x20 (col 2), each acked/checked → rows 0..5 with colours alternating. Seventh press → `invalid` pulse, no `place_valid`, `turn` unchanged.
- `check_done` with `win_found=1` after red's move → `game_over=1`, `winner_valid=1`, `winner=0`. Column keys are ignored. 0x2C → all heights 0, `turn=0`.
- Fill all 42 cells with `win_found=0` → after 42nd check: `game_over=1`, `winner_valid=0`.
- Reset asserted in PLACE before ack → next cycle `place_valid=0`, `height[col]=0`, `moves=0`.
- `place_ack` delayed 5 cycles → `place_col`, `place_row` and `place_color` stay stable throughout. A second column key during the wait → no extra placement.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect Four constants, colour/state enums and HID keycodes used by
// the move sequencer and its column-height storage.
package connect4_pkg;
    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 6;
    localparam int COL_W    = 3;
    localparam int ROW_W    = 3;
    localparam int MOVES_W  = 6;

    typedef enum logic {
        RED   = 1'b0,
        BLACK = 1'b1
    } color_t;

    typedef enum logic [1:0] {
        WAIT_KEY = 2'd0,
        PLACE    = 2'd1,
        CHECK    = 2'd2,
        OVER     = 2'd3
    } state_t;

    localparam logic [7:0] KEY_COL0     = 8'h1E;
    localparam logic [7:0] KEY_COL1     = 8'h1F;
    localparam logic [7:0] KEY_COL2     = 8'h20;
    localparam logic [7:0] KEY_COL3     = 8'h21;
    localparam logic [7:0] KEY_COL4     = 8'h22;
    localparam logic [7:0] KEY_COL5     = 8'h23;
    localparam logic [7:0] KEY_COL6     = 8'h24;
    localparam logic [7:0] KEY_NEW_GAME = 8'h2C;
endpackage

// File: rtl/drop_turn_controller_if.sv
// Placement request / win-check handshake between the move sequencer (master)
// and the board storage plus win checker (slave).
interface drop_turn_controller_if;
    import connect4_pkg::*;

    logic               place_valid;
    logic [COL_W-1:0]   place_col;
    logic [ROW_W-1:0]   place_row;
    logic               place_color;
    logic               place_ack;
    logic               check_done;
    logic               win_found;

    modport master (
        output place_valid, place_col, place_row, place_color,
        input  place_ack, check_done, win_found
    );

    modport slave (
        input  place_valid, place_col, place_row, place_color,
        output place_ack, check_done, win_found
    );
endinterface

// File: rtl/column_heights.sv
// Per-column fill counters: saturating increment, bulk clear, one read port
// and a full flag per column.
module column_heights
    import connect4_pkg::*;
#(
    parameter int NUM_COLS = connect4_pkg::NUM_COLS,
    parameter int NUM_ROWS = connect4_pkg::NUM_ROWS
) (
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic                inc_en,
    input  logic [COL_W-1:0]    inc_col,
    input  logic                clr,
    input  logic [COL_W-1:0]    rd_col,
    output logic [ROW_W-1:0]    rd_height,
    output logic [NUM_COLS-1:0] full
);
    localparam logic [ROW_W-1:0] ROWS_MAX = ROW_W'(NUM_ROWS);

    logic [ROW_W-1:0] height_q [NUM_COLS];

    always_ff @(posedge frame_clk) begin
        if (Reset || clr) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                height_q[i] <= '0;
            end
        end else if (inc_en && !full[inc_col]) begin
            height_q[inc_col] <= height_q[inc_col] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_full
        assign full[g] = (height_q[g] == ROWS_MAX);
    end

    assign rd_height = height_q[rd_col];
endmodule

// File: rtl/drop_turn_controller.sv
// Connect Four move sequencer: edge-detects column keys, issues one placement
// per accepted press, waits for the win verdict, then passes the turn.
module drop_turn_controller
    import connect4_pkg::*;
#(
    parameter int NUM_COLS = connect4_pkg::NUM_COLS,
    parameter int NUM_ROWS = connect4_pkg::NUM_ROWS
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [7:0]             keycode,
    drop_turn_controller_if.master bus,
    output logic                   turn,
    output logic                   invalid,
    output logic                   game_over,
    output logic                   winner_valid,
    output logic                   winner
);
    localparam logic [MOVES_W-1:0] MAX_MOVES = MOVES_W'(NUM_COLS * NUM_ROWS);

    state_t                state;
    logic [7:0]            keycode_p1;
    logic [MOVES_W-1:0]    moves;
    logic                  press;
    logic                  key_is_col;
    logic [COL_W-1:0]      key_col;
    logic                  new_game;
    logic                  inc_en;
    logic                  clr_heights;
    logic [ROW_W-1:0]      col_height;
    logic [NUM_COLS-1:0]   col_full;

    // A press is a change to a non-zero code; a held key never repeats.
    assign press = (keycode != keycode_p1) && (keycode != 8'h00);

    always_comb begin
        key_is_col = 1'b1;
        key_col    = '0;
        case (keycode)
            KEY_COL0: key_col = 3'd0;
            KEY_COL1: key_col = 3'd1;
            KEY_COL2: key_col = 3'd2;
            KEY_COL3: key_col = 3'd3;
            KEY_COL4: key_col = 3'd4;
            KEY_COL5: key_col = 3'd5;
            KEY_COL6: key_col = 3'd6;
            default:  key_is_col = 1'b0;
        endcase
    end

    assign new_game    = press && (keycode == KEY_NEW_GAME);
    assign inc_en      = (state == PLACE) && bus.place_valid && bus.place_ack;
    assign clr_heights = (state == OVER) && new_game;

    column_heights #(
        .NUM_COLS (NUM_COLS),
        .NUM_ROWS (NUM_ROWS)
    ) u_heights (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .inc_en    (inc_en),
        .inc_col   (bus.place_col),
        .clr       (clr_heights),
        .rd_col    (key_col),
        .rd_height (col_height),
        .full      (col_full)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state           <= WAIT_KEY;
            keycode_p1      <= 8'h00;
            moves           <= '0;
            turn            <= RED;
            invalid         <= 1'b0;
            game_over       <= 1'b0;
            winner_valid    <= 1'b0;
            winner          <= RED;
            bus.place_valid <= 1'b0;
            bus.place_col   <= '0;
            bus.place_row   <= '0;
            bus.place_color <= RED;
        end else begin
            keycode_p1 <= keycode;
            invalid    <= 1'b0;
            case (state)
                WAIT_KEY: begin
                    if (press && key_is_col) begin
                        if (col_full[key_col]) begin
                            invalid <= 1'b1;
                        end else begin
                            bus.place_col   <= key_col;
                            bus.place_row   <= col_height;
                            bus.place_color <= turn;
                            bus.place_valid <= 1'b1;
                            state           <= PLACE;
                        end
                    end
                end
                PLACE: begin
                    if (bus.place_valid && bus.place_ack) begin
                        bus.place_valid <= 1'b0;
                        moves           <= moves + 1'b1;
                        state           <= CHECK;
                    end
                end
                CHECK: begin
                    // moves already includes the placement being judged.
                    if (bus.check_done) begin
                        if (bus.win_found) begin
                            game_over    <= 1'b1;
                            winner_valid <= 1'b1;
                            winner       <= turn;
                            state        <= OVER;
                        end else if (moves == MAX_MOVES) begin
                            game_over    <= 1'b1;
                            winner_valid <= 1'b0;
                            state        <= OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= WAIT_KEY;
                        end
                    end
                end
                OVER: begin
                    if (new_game) begin
                        moves        <= '0;
                        turn         <= RED;
                        game_over    <= 1'b0;
                        winner_valid <= 1'b0;
                        winner       <= RED;
                        state        <= WAIT_KEY;
                    end
                end
                default: state <= WAIT_KEY;
            endcase
        end
    end
endmodule

// File: tb/tb_drop_turn_controller.sv
// Randomized scoreboard bench for drop_turn_controller against a game-level model.
module tb_drop_turn_controller;
    import connect4_pkg::*;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       turn, invalid, game_over, winner_valid, winner;

    drop_turn_controller_if bus ();

    drop_turn_controller dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .bus          (bus),
        .turn         (turn),
        .invalid      (invalid),
        .game_over    (game_over),
        .winner_valid (winner_valid),
        .winner       (winner)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int col;
        int row;
        int color;
    } req_t;

    req_t exp_q[$];
    req_t cur;
    int   total = 0;
    int   bad   = 0;
    int   inv_exp  = 0;
    int   inv_seen = 0;
    bit   pv_prev  = 1'b0;
    bit   inv_prev = 1'b0;

    // Game model: column fill, move count, whose turn, end-of-game status.
    int m_h[7];
    int m_moves;
    int m_turn, m_over, m_wv, m_win;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 7; i++) m_h[i] = 0;
        m_moves = 0; m_turn = 0; m_over = 0; m_wv = 0; m_win = 0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_turn"}, int'(turn), m_turn);
        chk({tag, "_game_over"}, int'(game_over), m_over);
        chk({tag, "_winner_valid"}, int'(winner_valid), m_wv);
        chk({tag, "_winner"}, int'(winner), m_win);
    endtask

    // Monitor: pops the expected request when one appears and holds it to
    // that value for every cycle the request stays up.
    always @(negedge frame_clk) begin
        if (bus.place_valid) begin
            if (!pv_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", int'(bus.place_valid), 0);
                    cur.col = -1; cur.row = -1; cur.color = -1;
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (cur.col >= 0) begin
                chk("req_col", int'(bus.place_col), cur.col);
                chk("req_row", int'(bus.place_row), cur.row);
                chk("req_color", int'(bus.place_color), cur.color);
            end
        end
        if (invalid) begin
            inv_seen++;
            if (inv_prev) chk("invalid_width", int'(inv_prev), 0);
        end
        pv_prev  = bus.place_valid;
        inv_prev = invalid;
    end

    task automatic play(input int c, input int win, input int ack_dly,
                        input int hold, input logic [7:0] alt_key);
        keycode = KEY_COL0 + 8'(c);
        if (m_over != 0) begin
            tick();
            chk("over_ignores_col", int'(bus.place_valid), 0);
            keycode = 8'h00;
            tick();
            chk_status("over_hold");
            return;
        end
        if (m_h[c] == 6) begin
            inv_exp++;
            tick();
            chk("invalid_pulse", int'(invalid), 1);
            chk("invalid_no_req", int'(bus.place_valid), 0);
            keycode = 8'h00;
            tick();
            chk("invalid_drop", int'(invalid), 0);
            chk("invalid_turn", int'(turn), m_turn);
            return;
        end
        exp_q.push_back('{col: c, row: m_h[c], color: m_turn});
        tick();
        chk("req_latency", int'(bus.place_valid), 1);
        for (int i = 0; i < ack_dly; i++) begin
            if (i == 1 && alt_key != 8'h00) keycode = alt_key;
            tick();
        end
        bus.place_ack = 1'b1;
        tick();
        bus.place_ack = 1'b0;
        chk("req_drop_after_ack", int'(bus.place_valid), 0);
        bus.check_done = 1'b1;
        bus.win_found  = win[0];
        tick();
        bus.check_done = 1'b0;
        bus.win_found  = 1'b0;
        m_h[c]++;
        m_moves++;
        if (win != 0) begin
            m_over = 1; m_wv = 1; m_win = m_turn;
        end else if (m_moves == 42) begin
            m_over = 1; m_wv = 0;
        end else begin
            m_turn ^= 1;
        end
        chk_status("after_check");
        for (int i = 0; i < hold; i++) tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic new_game();
        keycode = KEY_NEW_GAME;
        tick();
        chk("newgame_no_req", int'(bus.place_valid), 0);
        keycode = 8'h00;
        tick();
        if (m_over != 0) model_clear();
        chk_status("new_game");
    endtask

    initial begin
        int iter;
        Reset          = 1'b1;
        keycode        = 8'h00;
        bus.place_ack  = 1'b0;
        bus.check_done = 1'b0;
        bus.win_found  = 1'b0;
        model_clear();
        repeat (3) tick();
        Reset = 1'b0;
        chk("rst_place_valid", int'(bus.place_valid), 0);
        chk("rst_place_col", int'(bus.place_col), 0);
        chk("rst_place_row", int'(bus.place_row), 0);
        chk("rst_invalid", int'(invalid), 0);
        chk_status("rst");

        // Held key yields exactly one placement.
        play(0, 0, 0, 6, 8'h00);

        // Stack column 2 to the top, then one press too many.
        for (int i = 0; i < 7; i++) play(2, 0, $urandom_range(0, 2), 0, 8'h00);

        // New-game key is ignored mid-game.
        new_game();

        // Red wins; column keys are then ignored until a new game.
        if (m_turn != 0) play(4, 0, 0, 0, 8'h00);
        play(3, 1, 1, 0, 8'h00);
        play(5, 0, 0, 0, 8'h00);
        new_game();
        play(2, 0, 0, 0, 8'h00);

        // Fill the whole board in random order with no winner.
        iter = 0;
        while (m_moves < 42 && iter < 800) begin
            play($urandom_range(0, 6), 0, $urandom_range(0, 3), 0, 8'h00);
            iter++;
        end
        chk("fill_completed", m_moves, 42);
        play(1, 0, 0, 0, 8'h00);
        new_game();

        // Reset while a request is outstanding.
        play(5, 0, 0, 0, 8'h00);
        keycode = KEY_COL5;
        exp_q.push_back('{col: 5, row: m_h[5], color: m_turn});
        tick();
        chk("pre_reset_req", int'(bus.place_valid), 1);
        Reset   = 1'b1;
        keycode = 8'h00;
        tick();
        Reset = 1'b0;
        model_clear();
        chk("reset_abort_req", int'(bus.place_valid), 0);
        chk_status("reset_abort");
        play(5, 0, 0, 0, 8'h00);

        // Slow ack with a second column key arriving during the wait.
        play(6, 0, 5, 4, KEY_COL1);
        play(6, 0, $urandom_range(0, 3), 0, 8'h00);

        repeat (3) tick();
        chk("invalid_count", inv_seen, inv_exp);
        chk("pending_requests", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
